lram_mem: RTL
=============

# lram_mem

- Parametrised single-clock distributed-RAM (LUTRAM) memory.
- Successor to the fixed 8×8 LUTRAM ROM: adds configurable width and depth, a synchronous write port, and a hardware clear sequencer.
- Read side is a valid/ready request/response channel with one registered pipeline stage.
- Sits between a host register interface and datapath lookup logic as a small writable table.

## Interface

Parameters:
- WIDTH, 8: data bits per word (1..64).
- DEPTH, 64: words; power of two, 2..256.
- AW, $clog2(DEPTH): address width. Derived; never overridden.
- CLEAR_VAL, 0: WIDTH-bit value written to every word after reset.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- init_done  out  1  high once the clear sweep has finished.
- wr_en  in  1  write strobe.
- wr_addr  in  AW  write address.
- wr_data  in  WIDTH  write data.
- rd_req_valid  in  1  read request valid.
- rd_req_ready  out  1  read request accepted when high together with valid.
- rd_addr  in  AW  read address, sampled on acceptance.
- rd_rsp_valid  out  1  response valid.
- rd_rsp_ready  in  1  consumer ready.
- rd_rsp_data  out  WIDTH  response data.

## Operation

Storage:
- Storage is DEPTH×WIDTH LUTRAM with asynchronous read and synchronous write.
- The storage array has no reset. Its contents are defined only by the clear sweep.

State machine, states CLEAR and RUN:
- Reset forces CLEAR with clr_addr=0.
- In CLEAR, each cycle writes CLEAR_VAL to clr_addr and increments clr_addr.
- After writing address DEPTH-1, the FSM moves to RUN. clr_addr wraps to 0 and is unused in RUN.
- In CLEAR, wr_en is ignored (the write is dropped, not queued) and rd_req_ready=0.
- RUN is terminal until the next reset.

Write port (RUN only):
- wr_en=1 writes wr_data to wr_addr at the edge.

Read channel (RUN only):
- rd_req_ready = init_done & (!rd_rsp_valid | rd_rsp_ready).
- On accept (valid & ready), rd_rsp_data is loaded from mem[rd_addr] and rd_rsp_valid is set.
- If the response is consumed (rd_rsp_valid & rd_rsp_ready) with no new accept, rd_rsp_valid clears.
- Accept and consume in the same cycle: rd_rsp_valid stays 1 and the data is replaced. This gives full throughput of one read per cycle.
- While rd_rsp_valid & !rd_rsp_ready, rd_rsp_data holds stable. Later writes to that address do not alter the held value.

Read and write to the same address in the same cycle:
- The result depends on LRAM_BYPASS_EN (see Configuration).

Reset asserted mid-operation:
- All outputs return to their reset values immediately. Any in-flight response is discarded.
- The sweep restarts from address 0 after release. Data written before the reset is overwritten with CLEAR_VAL.

## Timing

Reset values:
- init_done=0, rd_req_ready=0, rd_rsp_valid=0, rd_rsp_data=0, FSM=CLEAR, clr_addr=0.

Clear sweep:
- Occupies exactly DEPTH rising edges after reset release. Edge k (1-based) writes address k-1.
- init_done goes high after edge DEPTH and is registered. It is observed high in the cycle following the last clear write.

Read latency:
- One cycle: request accepted at edge N gives rd_rsp_valid=1 with data after edge N.

Write-to-read visibility:
- A write at edge N is visible to a read accepted at edge N+1 or later.
- rd_req_ready is a combinational function of registered state and rd_rsp_ready only. There is no path from rd_req_valid to rd_req_ready.

## Configuration

LRAM_BYPASS_EN:
- Defined: when a read is accepted at the same edge as a write (wr_en=1, RUN) with wr_addr==rd_addr, rd_rsp_data takes wr_data (write-first).
- Undefined: rd_rsp_data takes the pre-write contents (read-first). This is pure LUTRAM behaviour with no forwarding mux.
- Both builds behave identically for differing addresses.

## Test plan

Use WIDTH=8, DEPTH=64, CLEAR_VAL=8'hA5 unless stated.

1. Clear sweep: release reset, hold wr_en=1 with wr_addr=3, wr_data=8'h11 throughout.
   - init_done rises exactly 64 cycles after release; rd_req_ready stays 0 before that.
   - Reading all 64 addresses returns 8'hA5, including address 3 (the write during CLEAR is dropped).
2. Write/read back: write 8'h3C to 5 and 8'hC3 to 63, then read 5, 63 and 0 back-to-back with rd_rsp_ready=1.
   - Responses are 8'h3C, 8'hC3, 8'hA5 on three consecutive cycles, each one cycle after its accept.
3. Back-pressure: accept a read of 5, hold rd_rsp_ready=0 for 4 cycles, and write 8'h77 to 5 during the stall.
   - rd_rsp_data stays 8'h3C and rd_req_ready=0 throughout the stall.
   - After ready rises, the next read of 5 returns 8'h77.
4. Same-cycle collision: address 9 holds 8'hA5; write 8'h42 to 9 and accept a read of 9 at the same edge.
   - Response is 8'h42 with LRAM_BYPASS_EN defined, 8'hA5 without.
   - The following read of 9 returns 8'h42 in both builds.
5. Reset mid-stream: assert reset while rd_rsp_valid=1.
   - rd_rsp_valid and init_done drop immediately and the sweep reruns for 64 cycles.
   - Previously written address 5 then reads 8'hA5.
6. Sizing corner: WIDTH=1, DEPTH=2.
   - init_done rises 2 cycles after reset release.
   - Alternating writes and reads of both addresses return the written bits.

Source files
------------

// File: rtl/lram_mem.sv
// Parametrised single-clock LUTRAM table with a post-reset clear sweep and a
// one-stage valid/ready read channel. Define LRAM_BYPASS_EN for write-first collisions.
module lram_mem #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 64,
    parameter int               AW        = $clog2(DEPTH),
    parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    output logic             init_done,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_req_valid,
    output logic             rd_req_ready,
    input  logic [AW-1:0]    rd_addr,
    output logic             rd_rsp_valid,
    input  logic             rd_rsp_ready,
    output logic [WIDTH-1:0] rd_rsp_data
);

    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

    typedef struct packed {
        logic             we;
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
    } wreq_t;

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } rsp_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    clr_addr_q, clr_addr_d;
    logic             init_done_q, init_done_d;
    rsp_t             rsp_q, rsp_d;
    wreq_t            mw;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_word;
    logic             accept;
    logic             consume;

    // Sweep sequencer: one CLEAR_VAL write per cycle, then RUN forever.
    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        init_done_d = init_done_q;
        mw.we       = 1'b0;
        mw.addr     = wr_addr;
        mw.data     = wr_data;
        case (state_q)
            CLEAR: begin
                mw.we      = 1'b1;
                mw.addr    = clr_addr_q;
                mw.data    = CLEAR_VAL;
                clr_addr_d = clr_addr_q + AW'(1);
                if (clr_addr_q == AW'(DEPTH - 1)) begin
                    state_d     = RUN;
                    init_done_d = 1'b1;
                end
            end
            RUN: begin
                mw.we = wr_en;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= CLEAR;
            clr_addr_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            init_done_q <= init_done_d;
        end
    end

    // Storage is deliberately unreset; the sweep defines its contents.
    always_ff @(posedge clock) begin
        if (mw.we)
            mem[mw.addr] <= mw.data;
    end

    assign rd_req_ready = init_done_q & (~rsp_q.valid | rd_rsp_ready);
    assign accept       = rd_req_valid & rd_req_ready;
    assign consume      = rsp_q.valid & rd_rsp_ready;

`ifdef LRAM_BYPASS_EN
    // Accept implies RUN, so a raw wr_en here is a real write.
    assign rd_word = (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
`else
    assign rd_word = mem[rd_addr];
`endif

    always_comb begin
        rsp_d = rsp_q;
        if (accept) begin
            rsp_d.valid = 1'b1;
            rsp_d.data  = rd_word;
        end else if (consume) begin
            rsp_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            rsp_q <= '0;
        else
            rsp_q <= rsp_d;
    end

    assign init_done    = init_done_q;
    assign rd_rsp_valid = rsp_q.valid;
    assign rd_rsp_data  = rsp_q.data;

endmodule
